ct_mmu_jtlb_data_ctrl: RTL

//  Sequencer/arbiter in front of the 4-way x 256-entry JTLB data array (2 banks: bank1=ways3:2, bank0=ways1:0).

---
 rtl/ct_mmu_jtlb_data_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ct_mmu_jtlb_data_ctrl.sv
// ---------------------------------------------------------------------------
// ct_mmu_jtlb_data_ctrl
//
// This block arbitrates the single port of the 4-way x 2**IDX_W-entry JTLB
// data array. The array is split into two banks:
//   bank1 holds ways 3:2
//   bank0 holds ways 1:0
//
// Three requesters share the port. In priority order they are:
//   1. the invalidate-all sweep
//   2. a refill write
//   3. a lookup read
//
// The block also owns the invalidate-all FSM. That FSM writes zero to every
// index on consecutive cycles.
//
// Ports
//   forever_cpuclk, cpurst_b   clock and asynchronous active-low reset
//   lookup_req/idx             read request for all four ways at one index
//   lookup_gnt                 combinational grant for the lookup
//   lookup_vld/data            read data returned one cycle after the grant
//   refill_req/idx/way/data    write request; refill_way is one-hot
//   refill_gnt                 combinational grant for the refill
//   inv_all_req                level request that starts the sweep
//   inv_all_busy               high while the sweep owns the port
//   inv_all_done               one-cycle pulse after the last sweep write
//   jtlb_data_cen0/1           bank chip enables
//   jtlb_data_wen              per-way write enables
//   jtlb_data_idx              array index
//   jtlb_data_din              array write data
//   jtlb_data_dout0/1          array read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module ct_mmu_jtlb_data_ctrl #(
  parameter int IDX_W = 8,
  parameter int WAY_W = 42
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,

  input  logic                 lookup_req,
  input  logic [IDX_W-1:0]     lookup_idx,
  output logic                 lookup_gnt,
  output logic                 lookup_vld,
  output logic [4*WAY_W-1:0]   lookup_data,

  input  logic                 refill_req,
  input  logic [IDX_W-1:0]     refill_idx,
  input  logic [3:0]           refill_way,
  input  logic [WAY_W-1:0]     refill_data,
  output logic                 refill_gnt,

  input  logic                 inv_all_req,
  output logic                 inv_all_busy,
  output logic                 inv_all_done,

  output logic                 jtlb_data_cen0,
  output logic                 jtlb_data_cen1,
  output logic [3:0]           jtlb_data_wen,
  output logic [IDX_W-1:0]     jtlb_data_idx,
  output logic [2*WAY_W-1:0]   jtlb_data_din,
  input  logic [2*WAY_W-1:0]   jtlb_data_dout0,
  input  logic [2*WAY_W-1:0]   jtlb_data_dout1
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] CNT_LAST = '1;
  localparam logic [IDX_W-1:0] CNT_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           state_p0;
  state_t           state_nxt;
  logic [IDX_W-1:0] sweep_cnt_p0;
  logic [IDX_W-1:0] sweep_cnt_nxt;
  logic             sweep_act;
  logic             lookup_vld_p1;

  // -------------------------------------------------------------------------
  // Stage p0: FSM state register and sweep counter.
  // A reset arriving mid-sweep aborts the sweep. Software is expected to
  // reissue inv_all_req afterwards.
  // -------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_p0     <= ST_IDLE;
      sweep_cnt_p0 <= '0;
    end else begin
      state_p0     <= state_nxt;
      sweep_cnt_p0 <= sweep_cnt_nxt;
    end
  end

  // Next-state logic.
  // inv_all_req is only looked at in IDLE. A request raised during SWEEP or
  // DONE is dropped rather than queued.
  always_comb begin
    state_nxt     = state_p0;
    sweep_cnt_nxt = sweep_cnt_p0;
    case (state_p0)
      ST_IDLE: begin
        if (inv_all_req) begin
          state_nxt     = ST_SWEEP;
          sweep_cnt_nxt = '0;
        end
      end
      ST_SWEEP: begin
        sweep_cnt_nxt = sweep_cnt_p0 + CNT_ONE;
        if (sweep_cnt_p0 == CNT_LAST) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic.
  // The sweep locks out both other requesters. Outside the sweep, a refill
  // wins over a lookup. An idle port drives all zeros so that the array's
  // clock gate stays closed.
  always_comb begin
    sweep_act      = (state_p0 == ST_SWEEP);
    inv_all_busy   = sweep_act;
    inv_all_done   = (state_p0 == ST_DONE);
    refill_gnt     = !sweep_act && refill_req;
    lookup_gnt     = !sweep_act && !refill_req && lookup_req;

    jtlb_data_cen0 = 1'b0;
    jtlb_data_cen1 = 1'b0;
    jtlb_data_wen  = 4'b0000;
    jtlb_data_idx  = '0;
    jtlb_data_din  = '0;

    if (sweep_act) begin
      jtlb_data_cen0 = 1'b1;
      jtlb_data_cen1 = 1'b1;
      jtlb_data_wen  = 4'b1111;
      jtlb_data_idx  = sweep_cnt_p0;
    end else if (refill_req) begin
      // A refill with no way selected is still granted, so the requester can
      // retire it, but it enables neither bank.
      jtlb_data_cen1 = |refill_way[3:2];
      jtlb_data_cen0 = |refill_way[1:0];
      jtlb_data_wen  = refill_way;
      jtlb_data_idx  = refill_idx;
      jtlb_data_din  = {refill_data, refill_data};
    end else if (lookup_req) begin
      jtlb_data_cen0 = 1'b1;
      jtlb_data_cen1 = 1'b1;
      jtlb_data_idx  = lookup_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: the lookup valid flag follows the grant by one cycle, which is
  // the array's read latency. The read data itself comes straight from the
  // array outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      lookup_vld_p1 <= 1'b0;
    end else begin
      lookup_vld_p1 <= lookup_gnt;
    end
  end

  assign lookup_vld  = lookup_vld_p1;
  assign lookup_data = {jtlb_data_dout1, jtlb_data_dout0};

endmodule
